flash_bus_bridge: RTL and testbench
===================================

FLASH_BUS_BRIDGE -- requirements
Module: flash_bus_bridge

Interface
REQ-001 SHALL have parameter FLASH_PAGE, default 4'hE: value of i_ADDRESS_BUS[15:12] that selects the 4 KiB flash window.
REQ-002 SHALL have parameter CTRL_ADDR, default 16'hDFF0: address of the control/status register.
REQ-003 SHALL have parameter TIMEOUT, default 16'd4095: maximum clk cycles allowed per flash transaction.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 i_E, i_Q  input  1 each  6809 bus phase clocks (asynchronous to clk).
REQ-007 i_RW  input  1  6809 read (1) / write (0).
REQ-008 i_ADDRESS_BUS  input  16  6809 address.
REQ-009 i_DataBus  input  8  6809 write data.
REQ-010 i_spi_ready  input  1  SPI engine ready; low while a transaction is in progress.
REQ-011 i_spi_data  input  8  byte read by the SPI engine.
REQ-012 o_spi_ce  output  1  request strobe to the SPI engine.
REQ-013 o_spi_rw, o_spi_addr[11:0], o_spi_wdata[7:0]  output  direction, window offset and write byte for the SPI engine.
REQ-014 o_MRDY  output  1  6809 memory-ready; low stretches the bus cycle.
REQ-015 o_data[7:0], o_data_oe  output  read data to the CPU and its drive enable.

Function
REQ-016 i_E and i_Q SHALL pass through 2-flop synchronizers; a cycle start is the rising edge of synchronized E.
REQ-017 At a cycle start, address, RW and data SHALL be latched; a window hit is latched addr[15:12]==FLASH_PAGE; a control hit is latched address==CTRL_ADDR.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_BUSY, WAIT_DONE and HOLD.
REQ-019 IDLE->REQ on a window hit at a cycle start when the access is permitted; o_MRDY SHALL go low in that same clk.
REQ-020 REQ: o_spi_ce=1 with o_spi_rw/addr/wdata stable; advance to WAIT_BUSY after exactly 1 clk.
REQ-021 WAIT_BUSY: hold o_spi_ce=1 until i_spi_ready==0, then drop o_spi_ce and go to WAIT_DONE.
REQ-022 WAIT_DONE: on i_spi_ready==1, latch i_spi_data into the read buffer (reads only), set o_MRDY=1, go to HOLD.
REQ-023 HOLD: return to IDLE on the falling edge of synchronized E; no new request SHALL be accepted before IDLE.
REQ-024 A permitted access is a read, or a write while wp==0.
REQ-025 Window write with wp==1: no SPI request, o_MRDY stays 1, wp_err set, FSM goes to HOLD.
REQ-026 o_data_oe SHALL be 1 only while synchronized E==1 during a read cycle with a window or control hit and o_MRDY==1.
REQ-027 o_data SHALL be the read buffer for window reads and {5'b0, wp_err, to_err, wp} for control reads.
REQ-028 Control write SHALL take effect at the E falling edge: wp<=D0; D1==1 clears to_err and wp_err; the write is never stretched.
REQ-029 A 16-bit timeout counter SHALL clear on entry to REQ and increment in REQ, WAIT_BUSY and WAIT_DONE.
REQ-030 When the timeout counter reaches TIMEOUT: o_spi_ce=0, read buffer=8'hFF, to_err=1, o_MRDY=1, go to HOLD.
REQ-031 If timeout and i_spi_ready rise in the same clk, completion SHALL win.
REQ-032 Cycles that hit neither the window nor CTRL_ADDR SHALL be ignored: o_MRDY=1, o_data_oe=0.

Reset
REQ-033 reset==0 SHALL force IDLE, at any state including mid-transaction.
REQ-034 During reset: o_spi_ce=0, o_MRDY=1, o_data_oe=0, o_data=0, o_spi_rw=1, o_spi_addr=0, o_spi_wdata=0.
REQ-035 During reset: read buffer=0, wp=1, to_err=0, wp_err=0, timeout counter=0, cache invalid.

Configuration
REQ-036 With FLASH_READ_CACHE_EN defined, a one-entry cache SHALL hold the last completed read's offset and byte.
REQ-037 With FLASH_READ_CACHE_EN defined, a read hitting a valid entry SHALL return the cached byte with no SPI request and o_MRDY held 1.
REQ-038 With FLASH_READ_CACHE_EN defined, any window write, a timeout or reset SHALL invalidate the cache.
REQ-039 Without FLASH_READ_CACHE_EN, every window read SHALL issue an SPI request and no cache logic SHALL be present.

Verification
REQ-040 Read 0xE123, engine drops ready 3 clk after ce and returns 0x5A after 80 clk -> o_spi_addr=0x123, o_spi_rw=1, o_MRDY low throughout, o_data=0x5A with o_data_oe=1.
REQ-041 Write 0x77 to 0xE010 after reset (wp=1) -> no o_spi_ce, o_MRDY stays 1, read of 0xDFF0 returns 0x05.
REQ-042 Write 0x00 to 0xDFF0, then write 0x77 to 0xE010 -> o_spi_ce pulse, o_spi_wdata=0x77, o_spi_rw=0, o_MRDY released when ready returns.
REQ-043 Read 0xE000 with ready never falling -> o_MRDY released after 4095 clk, o_data=0xFF, status bit1=1; write 0x02 to 0xDFF0 -> status bit1=0.
REQ-044 Assert reset in WAIT_DONE -> next clk: o_MRDY=1, o_spi_ce=0, FSM IDLE, status=0x01.
REQ-045 With FLASH_READ_CACHE_EN: two consecutive reads of 0xE200 -> only one o_spi_ce; second read returns the same byte with o_MRDY never low.

Source files
------------

// File: rtl/flash_bus_bridge_if.sv
// flash_bus_bridge_if
//   Groups the 6809 bus signals and the SPI engine handshake of the flash
//   bus bridge into a single bundle.
//   slave  modport : the bridge (takes bus phases/address/data and SPI status,
//                    drives MRDY, read data and SPI requests)
//   master modport : the CPU side and SPI engine (drive what the bridge reads)
//   Signals:
//     i_E, i_Q          6809 phase clocks (asynchronous to clk)
//     i_RW              1 = read, 0 = write
//     i_ADDRESS_BUS     6809 address
//     i_DataBus         6809 write data
//     i_spi_ready       SPI engine ready (low while busy)
//     i_spi_data        byte returned by the SPI engine
//     o_spi_ce          request strobe to the SPI engine
//     o_spi_rw          SPI direction (1 = read)
//     o_spi_addr        offset inside the flash window
//     o_spi_wdata       byte to write
//     o_MRDY            6809 memory ready (low stretches the cycle)
//     o_data, o_data_oe read data to the CPU and its drive enable
interface flash_bus_bridge_if;
    logic        i_E;
    logic        i_Q;
    logic        i_RW;
    logic [15:0] i_ADDRESS_BUS;
    logic [7:0]  i_DataBus;
    logic        i_spi_ready;
    logic [7:0]  i_spi_data;
    logic        o_spi_ce;
    logic        o_spi_rw;
    logic [11:0] o_spi_addr;
    logic [7:0]  o_spi_wdata;
    logic        o_MRDY;
    logic [7:0]  o_data;
    logic        o_data_oe;

    modport slave (
        input  i_E, i_Q, i_RW, i_ADDRESS_BUS, i_DataBus, i_spi_ready, i_spi_data,
        output o_spi_ce, o_spi_rw, o_spi_addr, o_spi_wdata, o_MRDY, o_data, o_data_oe
    );

    modport master (
        output i_E, i_Q, i_RW, i_ADDRESS_BUS, i_DataBus, i_spi_ready, i_spi_data,
        input  o_spi_ce, o_spi_rw, o_spi_addr, o_spi_wdata, o_MRDY, o_data, o_data_oe
    );
endinterface

// File: rtl/flash_bus_bridge.sv
// flash_bus_bridge
//   Maps a 4 KiB window of the 6809 address space onto an SPI flash engine
//   and exposes a control/status register. Flash accesses stretch the CPU
//   cycle through MRDY until the engine completes or a timeout expires.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-low reset
//     bus    flash_bus_bridge_if.slave (6809 bus + SPI engine handshake)
//   Parameters:
//     FLASH_PAGE  address[15:12] value selecting the flash window
//     CTRL_ADDR   address of the control/status register
//     TIMEOUT     maximum clk cycles per flash transaction
//   Status register read: {5'b0, wp_err, to_err, wp}
//   Control register write: D0 -> wp, D1 = 1 clears to_err and wp_err
//   Build option: define FLASH_READ_CACHE_EN for a one-entry read cache.
module flash_bus_bridge #(
    parameter logic [3:0]  FLASH_PAGE = 4'hE,
    parameter logic [15:0] CTRL_ADDR  = 16'hDFF0,
    parameter logic [15:0] TIMEOUT    = 16'd4095
) (
    input  logic              clk,
    input  logic              reset,
    flash_bus_bridge_if.slave bus
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        e_s1, e_s2, e_prev;
    logic        q_s1, q_sync_unused;
    logic        e_rise, e_fall;

    logic        rw_l;
    logic [11:0] addr_l;
    logic [7:0]  data_l;
    logic        win_l, ctl_l;

    logic [7:0]  rbuf;
    logic        wp, to_err, wp_err;
    logic [15:0] tcnt;
    logic [7:0]  status;

    logic        win_now, ctl_now;
    logic        accept, start_req, wr_blocked, active, tmo, done, abort, ctl_wr;
    logic        cache_hit;

    logic        spi_ce, mrdy, oe;
    logic [7:0]  rdata;

    // Phase clock synchronizers. Q is synchronized alongside E but the
    // bridge keys all of its timing off E edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_s1          <= 1'b0;
            e_s2          <= 1'b0;
            e_prev        <= 1'b0;
            q_s1          <= 1'b0;
            q_sync_unused <= 1'b0;
        end else begin
            e_s1          <= bus.i_E;
            e_s2          <= e_s1;
            e_prev        <= e_s2;
            q_s1          <= bus.i_Q;
            q_sync_unused <= q_s1;
        end
    end

    assign e_rise = e_s2 && !e_prev;
    assign e_fall = !e_s2 && e_prev;

    // Decode is taken straight from the bus at the cycle start so the FSM
    // can leave IDLE (and pull MRDY) in the same clk the address is latched.
    assign win_now    = (bus.i_ADDRESS_BUS[15:12] == FLASH_PAGE);
    assign ctl_now    = (bus.i_ADDRESS_BUS == CTRL_ADDR);
    assign accept     = (state == IDLE) && e_rise && win_now;
    assign start_req  = accept && (bus.i_RW ? !cache_hit : !wp);
    assign wr_blocked = accept && !bus.i_RW && wp;
    assign active     = (state == REQ) || (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign tmo        = active && (tcnt >= TIMEOUT);
    assign done       = (state == WAIT_DONE) && bus.i_spi_ready;
    // Completion beats a timeout landing in the same clk.
    assign abort      = tmo && !done;
    assign ctl_wr     = e_fall && ctl_l && !rw_l;
    assign status     = {5'b0, wp_err, to_err, wp};

`ifdef FLASH_READ_CACHE_EN
    logic        cache_valid;
    logic [11:0] cache_off;
    logic [7:0]  cache_data;
    logic        cache_serve;

    assign cache_hit   = cache_valid && (cache_off == bus.i_ADDRESS_BUS[11:0]);
    assign cache_serve = accept && bus.i_RW && cache_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cache_valid <= 1'b0;
            cache_off   <= '0;
            cache_data  <= '0;
        end else if (e_rise && win_now && !bus.i_RW) begin
            cache_valid <= 1'b0;
        end else if (abort) begin
            cache_valid <= 1'b0;
        end else if (done && rw_l) begin
            cache_valid <= 1'b1;
            cache_off   <= addr_l;
            cache_data  <= bus.i_spi_data;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Datapath: cycle latches, read buffer, status bits, timeout counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rw_l   <= 1'b1;
            addr_l <= '0;
            data_l <= '0;
            win_l  <= 1'b0;
            ctl_l  <= 1'b0;
            rbuf   <= '0;
            wp     <= 1'b1;
            to_err <= 1'b0;
            wp_err <= 1'b0;
            tcnt   <= '0;
        end else begin
            if (e_rise) begin
                rw_l   <= bus.i_RW;
                addr_l <= bus.i_ADDRESS_BUS[11:0];
                data_l <= bus.i_DataBus;
                win_l  <= win_now;
                ctl_l  <= ctl_now;
            end

            if (start_req)
                tcnt <= '0;
            else if (active)
                tcnt <= tcnt + 16'd1;

            if (done && rw_l)
                rbuf <= bus.i_spi_data;
            else if (abort)
                rbuf <= 8'hFF;
`ifdef FLASH_READ_CACHE_EN
            else if (cache_serve)
                rbuf <= cache_data;
`endif

            // Error flags set after the clear so a same-clk event is kept.
            if (ctl_wr) begin
                wp <= data_l[0];
                if (data_l[1]) begin
                    to_err <= 1'b0;
                    wp_err <= 1'b0;
                end
            end
            if (abort)
                to_err <= 1'b1;
            if (wr_blocked)
                wp_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_req)
                    state_nxt = REQ;
                else if (accept)
                    state_nxt = HOLD;
            end
            REQ: begin
                state_nxt = tmo ? HOLD : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tmo)
                    state_nxt = HOLD;
                else if (!bus.i_spi_ready)
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.i_spi_ready || tmo)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (e_fall)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        spi_ce = 1'b0;
        mrdy   = 1'b1;
        oe     = 1'b0;
        rdata  = '0;
        if (reset) begin
            spi_ce = (state == REQ) || (state == WAIT_BUSY);
            mrdy   = !(active || start_req);
            // e_prev excludes the cycle-start clk, when the latches still
            // describe the previous bus cycle.
            oe     = e_s2 && e_prev && rw_l && (win_l || ctl_l) && mrdy;
            if (oe)
                rdata = win_l ? rbuf : status;
        end
    end

    assign bus.o_spi_ce    = spi_ce;
    assign bus.o_spi_rw    = rw_l;
    assign bus.o_spi_addr  = addr_l;
    assign bus.o_spi_wdata = data_l;
    assign bus.o_MRDY      = mrdy;
    assign bus.o_data      = rdata;
    assign bus.o_data_oe   = oe;

endmodule

// File: tb/tb_flash_bus_bridge.sv
// tb_flash_bus_bridge
//   Randomized self-checking bench for flash_bus_bridge. A behavioural SPI
//   engine serves requests from its own flash image; a reference model tracks
//   flash contents, status bits and (when FLASH_READ_CACHE_EN is defined) the
//   cached offset, and predicts read data, SPI requests and cycle stretching.
module tb_flash_bus_bridge;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    flash_bus_bridge_if bus();

    flash_bus_bridge #(
        .FLASH_PAGE(4'hE),
        .CTRL_ADDR (16'hDFF0),
        .TIMEOUT   (16'd4095)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI engine ----------------
    logic [7:0]  eng_mem [4096];
    int          drop_dly = 3;
    int          done_dly = 10;
    bit          hang     = 1'b0;
    logic [11:0] eng_a;
    logic        eng_rw;
    logic [7:0]  eng_wd;

    initial begin
        bus.i_spi_ready = 1'b1;
        bus.i_spi_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.o_spi_ce && bus.i_spi_ready && !hang) begin
                eng_a  = bus.o_spi_addr;
                eng_rw = bus.o_spi_rw;
                eng_wd = bus.o_spi_wdata;
                repeat (drop_dly) @(negedge clk);
                bus.i_spi_ready = 1'b0;
                repeat (done_dly) @(negedge clk);
                if (eng_rw)
                    bus.i_spi_data = eng_mem[eng_a];
                else
                    eng_mem[eng_a] = eng_wd;
                bus.i_spi_ready = 1'b1;
            end
        end
    end

    // ---------------- request monitor ----------------
    int          ce_cnt = 0;
    logic        ce_prev = 1'b0;
    logic [11:0] mon_addr;
    logic        mon_rw;
    logic [7:0]  mon_wdata;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_spi_ce && !ce_prev) begin
                ce_cnt++;
                mon_addr  = bus.o_spi_addr;
                mon_rw    = bus.o_spi_rw;
                mon_wdata = bus.o_spi_wdata;
            end
            ce_prev = bus.o_spi_ce;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [4096];
    bit          m_wp, m_to, m_wperr;
    bit          c_valid;
    logic [11:0] c_off;

    task automatic model_reset();
        m_wp    = 1'b1;
        m_to    = 1'b0;
        m_wperr = 1'b0;
        c_valid = 1'b0;
        c_off   = '0;
    endtask

    // One 6809 bus cycle; E is held high while MRDY is low, as the CPU would.
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                             output logic [7:0] rdata, output logic oe, output int low);
        int n;
        bit released;
        @(negedge clk);
        bus.i_ADDRESS_BUS = a;
        bus.i_RW          = rw;
        bus.i_DataBus     = d;
        @(negedge clk);
        bus.i_Q = 1'b1;
        @(negedge clk);
        bus.i_E = 1'b1;
        low = 0;
        n = 0;
        released = 1'b0;
        while (!released && n < 6000) begin
            @(negedge clk);
            n++;
            if (!bus.o_MRDY)
                low++;
            else if (n >= 5)
                released = 1'b1;
        end
        check_eq("mrdy_release_bound", 32'(released), 32'd1);
        bus.i_Q = 1'b0;
        repeat (2) @(negedge clk);
        rdata = bus.o_data;
        oe    = bus.o_data_oe;
        bus.i_E = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_op(input logic [15:0] a, input logic rw, input logic [7:0] d);
        logic [7:0] rd;
        logic       oe;
        int         low;
        int         ce0;
        bit         win, ctl, exp_ce;
        logic [7:0] exp_d;
        win    = (a[15:12] == 4'hE);
        ctl    = (a == 16'hDFF0);
        exp_ce = 1'b0;
        if (win && rw) begin
            exp_ce = 1'b1;
`ifdef FLASH_READ_CACHE_EN
            if (c_valid && c_off == a[11:0])
                exp_ce = 1'b0;
`endif
        end
        if (win && !rw)
            exp_ce = !m_wp;
        exp_d = win ? ref_mem[a[11:0]] : {5'b0, m_wperr, m_to, m_wp};

        ce0 = ce_cnt;
        bus_cycle(a, rw, d, rd, oe, low);

        check_eq("spi_requests", 32'(ce_cnt - ce0), 32'(exp_ce));
        check_eq("mrdy_stretched", 32'(low > 0), 32'(exp_ce));
        if (exp_ce) begin
            check_eq("spi_addr", 32'(mon_addr), 32'(a[11:0]));
            check_eq("spi_rw", 32'(mon_rw), 32'(rw));
            if (!rw)
                check_eq("spi_wdata", 32'(mon_wdata), 32'(d));
        end
        if (rw && (win || ctl)) begin
            check_eq("data_oe", 32'(oe), 32'd1);
            check_eq(win ? "flash_rdata" : "status_rdata", 32'(rd), 32'(exp_d));
        end else begin
            check_eq("data_oe", 32'(oe), 32'd0);
        end

        if (win && rw) begin
            c_valid = 1'b1;
            c_off   = a[11:0];
        end
        if (win && !rw) begin
            c_valid = 1'b0;
            if (m_wp)
                m_wperr = 1'b1;
            else
                ref_mem[a[11:0]] = d;
        end
        if (ctl && !rw) begin
            m_wp = d[0];
            if (d[1]) begin
                m_to    = 1'b0;
                m_wperr = 1'b0;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  rd;
        logic        oe;
        int          low;
        int          ce0;
        int          n;
        logic [11:0] off;
        logic [15:0] a;
        logic [7:0]  v;

        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            eng_mem[i] = v;
        end
        ref_mem[12'h123] = 8'h5A;
        eng_mem[12'h123] = 8'h5A;

        bus.i_E = 1'b0;
        bus.i_Q = 1'b0;
        bus.i_RW = 1'b1;
        bus.i_ADDRESS_BUS = 16'h0000;
        bus.i_DataBus = 8'h00;
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_eq("rst_spi_ce", 32'(bus.o_spi_ce), 32'd0);
        check_eq("rst_mrdy", 32'(bus.o_MRDY), 32'd1);
        check_eq("rst_data_oe", 32'(bus.o_data_oe), 32'd0);
        check_eq("rst_data", 32'(bus.o_data), 32'd0);
        check_eq("rst_spi_rw", 32'(bus.o_spi_rw), 32'd1);
        check_eq("rst_spi_addr", 32'(bus.o_spi_addr), 32'd0);
        check_eq("rst_spi_wdata", 32'(bus.o_spi_wdata), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Write-protected window write, then status shows wp_err | wp.
        do_op(16'hE010, 1'b0, 8'h77);
        bus_cycle(16'hDFF0, 1'b1, 8'h00, rd, oe, low);
        check_eq("wp_status_value", 32'(rd), 32'h05);

        // Unprotect and write.
        drop_dly = 2; done_dly = 10;
        do_op(16'hDFF0, 1'b0, 8'h00);
        do_op(16'hE010, 1'b0, 8'h77);

        // Long read.
        drop_dly = 3; done_dly = 77;
        do_op(16'hE123, 1'b1, 8'h00);

        // Back-to-back reads of one offset.
        drop_dly = 2; done_dly = 6;
        do_op(16'hE200, 1'b1, 8'h00);
        do_op(16'hE200, 1'b1, 8'h00);

        // Randomized mix.
        off = 12'h200;
        for (int i = 0; i < 40; i++) begin
            drop_dly = $urandom_range(1, 6);
            done_dly = $urandom_range(1, 40);
            case ($urandom_range(0, 5))
                0: do_op({4'hE, off}, 1'b1, 8'h00);
                1: begin
                    off = 12'($urandom);
                    do_op({4'hE, off}, 1'b1, 8'h00);
                end
                2: do_op({4'hE, ($urandom_range(0, 1) == 1) ? off : 12'($urandom)}, 1'b0, 8'($urandom));
                3: do_op(16'hDFF0, 1'b0, 8'($urandom_range(0, 3)));
                4: do_op(16'hDFF0, 1'b1, 8'h00);
                default: begin
                    a = 16'($urandom);
                    while (a[15:12] == 4'hE || a == 16'hDFF0)
                        a = 16'($urandom);
                    do_op(a, 1'($urandom), 8'($urandom));
                end
            endcase
        end

        // Engine never answers: timeout path.
        hang = 1'b1;
        ce0 = ce_cnt;
        bus_cycle(16'hE000, 1'b1, 8'h00, rd, oe, low);
        hang = 1'b0;
        check_eq("tmo_spi_requests", 32'(ce_cnt - ce0), 32'd1);
        check_eq("tmo_mrdy_low_window", 32'(low >= 4090 && low <= 4100), 32'd1);
        check_eq("tmo_data_oe", 32'(oe), 32'd1);
        check_eq("tmo_rdata", 32'(rd), 32'hFF);
        m_to = 1'b1;
        c_valid = 1'b0;
        bus_cycle(16'hDFF0, 1'b1, 8'h00, rd, oe, low);
        check_eq("tmo_status_bit1", 32'(rd[1]), 32'd1);
        do_op(16'hDFF0, 1'b0, 8'h02);
        bus_cycle(16'hDFF0, 1'b1, 8'h00, rd, oe, low);
        check_eq("tmo_cleared_bit1", 32'(rd[1]), 32'd0);

        // Reset while the engine is busy (bridge waiting for completion).
        drop_dly = 2; done_dly = 60;
        ce0 = ce_cnt;
        @(negedge clk);
        bus.i_ADDRESS_BUS = 16'hE456;
        bus.i_RW = 1'b1;
        bus.i_E = 1'b1;
        n = 0;
        while (n < 300 && !(ce_cnt != ce0 && !bus.o_spi_ce)) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_wait_done", 32'(n < 300), 32'd1);
        check_eq("wait_done_mrdy_low", 32'(bus.o_MRDY), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_mrdy", 32'(bus.o_MRDY), 32'd1);
        check_eq("midrst_spi_ce", 32'(bus.o_spi_ce), 32'd0);
        check_eq("midrst_data_oe", 32'(bus.o_data_oe), 32'd0);
        check_eq("midrst_data", 32'(bus.o_data), 32'd0);
        check_eq("midrst_spi_rw", 32'(bus.o_spi_rw), 32'd1);
        reset = 1'b1;
        bus.i_E = 1'b0;
        model_reset();
        n = 0;
        while (n < 300 && !bus.i_spi_ready) begin
            @(negedge clk);
            n++;
        end
        check_eq("engine_settled", 32'(bus.i_spi_ready), 32'd1);
        repeat (3) @(negedge clk);
        bus_cycle(16'hDFF0, 1'b1, 8'h00, rd, oe, low);
        check_eq("post_rst_status", 32'(rd), 32'h01);
        drop_dly = 1; done_dly = 4;
        do_op(16'hE456, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
